// File: rtl/axi_pkg.sv
// Shared AXI types for the write-response path: response codes and the
// layout of one outstanding AW entry as queued between AW and B.
package axi_pkg;

  localparam int unsigned BRESP_WIDTH  = 2;
  localparam int unsigned AW_ID_WIDTH  = 8;
  localparam int unsigned AW_LEN_WIDTH = 8;

  typedef enum logic [BRESP_WIDTH-1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  // Field order matches the packed vector the responder pushes: {id, len, err}.
  typedef struct packed {
    logic [AW_ID_WIDTH-1:0]  id;
    logic [AW_LEN_WIDTH-1:0] len;
    logic                    err;
  } aw_entry_t;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with registered occupancy count. Pointers wrap modulo
// Depth (power of two); the count carries one extra bit so full and empty
// are distinguishable. Storage is not reset; only pointers and count are.
module fifo_sync #(
  parameter int unsigned Width = 17,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;

  assign data_o  = mem[rd_ptr];
  assign full_o  = (count == CntW'(Depth));
  assign empty_o = (count == '0);

  // Entry storage: written on push, no reset needed.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (pop_i) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_b_resp_gen.sv
// AXI write-response generator for a slave port. Queues accepted AW
// requests, consumes W beats for the queue head, and returns one B per
// burst in AW order. Addresses outside [BaseAddr, BaseAddr+SizeBytes)
// answer SLVERR.
// Optional build macro AXI_B_RESP_LEN_CHECK_EN: also flags bursts whose
// wlast position disagrees with awlen as SLVERR.
module axi_b_resp_gen
  import axi_pkg::*;
#(
  parameter int unsigned          IdWidth   = 8,
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          LenWidth  = 8,
  parameter int unsigned          AwDepth   = 4,
  parameter logic [AddrWidth-1:0] BaseAddr  = 32'h0000_0000,
  parameter logic [AddrWidth-1:0] SizeBytes = 32'h0001_0000
) (
  input  logic                 aclk,
  input  logic                 rst_n,
  input  logic                 awvalid_i,
  output logic                 awready_o,
  input  logic [IdWidth-1:0]   awid_i,
  input  logic [AddrWidth-1:0] awaddr_i,
  input  logic [LenWidth-1:0]  awlen_i,
  input  logic                 wvalid_i,
  input  logic                 wlast_i,
  output logic                 wready_o,
  output logic                 bvalid_o,
  input  logic                 bready_i,
  output logic [IdWidth-1:0]   bid_o,
  output logic [1:0]           bresp_o
);

  localparam int unsigned EntryW = IdWidth + LenWidth + 1;

  logic [EntryW-1:0]   push_data;
  logic [EntryW-1:0]   head_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic                aw_hs;
  logic                w_hs;
  logic                end_hs;
  logic                burst_end;
  logic                len_err;
  logic [IdWidth-1:0]  head_id;
  logic [LenWidth-1:0] head_len;
  logic                head_err;
  logic [AddrWidth:0]  aw_diff;
  logic                aw_in_win;
  resp_t               bresp_q;

  // Window decode: the extra top bit of the difference is the borrow, i.e.
  // address below the base; otherwise the offset must be below the size.
  assign aw_diff   = {1'b0, awaddr_i} - {1'b0, BaseAddr};
  assign aw_in_win = !aw_diff[AddrWidth] && (aw_diff[AddrWidth-1:0] < SizeBytes);

  assign push_data = {awid_i, awlen_i, !aw_in_win};
  assign head_id   = head_data[EntryW-1 -: IdWidth];
  assign head_len  = head_data[1 +: LenWidth];
  assign head_err  = head_data[0];

  assign awready_o = rst_n && !fifo_full;
  assign aw_hs     = awvalid_i && awready_o;

  fifo_sync #(
    .Width (EntryW),
    .Depth (AwDepth)
  ) u_aw_fifo (
    .clk     (aclk),
    .rst_n   (rst_n),
    .push_i  (aw_hs),
    .data_i  (push_data),
    .pop_i   (end_hs),
    .data_o  (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef AXI_B_RESP_LEN_CHECK_EN
  logic [LenWidth-1:0] beat_cnt;
  logic                at_last;

  // A burst ends on wlast or on reaching beat awlen, whichever comes first;
  // any disagreement between the two marks the burst as errored.
  assign at_last   = (beat_cnt == head_len);
  assign burst_end = wlast_i || at_last;
  assign len_err   = (wlast_i != at_last);

  // Beat index within the head burst; restarts when the burst ends.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (w_hs) begin
      if (burst_end) begin
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + LenWidth'(1);
      end
    end
  end
`else
  logic len_unused;

  assign burst_end  = wlast_i;
  assign len_err    = 1'b0;
  assign len_unused = ^head_len;
`endif

  // The final beat of a burst is held off while an earlier B is still
  // unaccepted, so the B register never has to hold two responses.
  assign wready_o = !fifo_empty && !(burst_end && bvalid_o && !bready_i);
  assign w_hs     = wvalid_i && wready_o;
  assign end_hs   = w_hs && burst_end;

  assign bresp_o = bresp_q;

  // B output register: loads on the ending beat (reloading back-to-back if
  // the previous B is accepted on the same edge), otherwise drops on accept.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_o <= 1'b0;
      bid_o    <= '0;
      bresp_q  <= OKAY;
    end else if (end_hs) begin
      bvalid_o <= 1'b1;
      bid_o    <= head_id;
      bresp_q  <= (head_err || len_err) ? SLVERR : OKAY;
    end else if (bready_i) begin
      bvalid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_b_resp_gen.sv
// Self-checking bench for axi_b_resp_gen: a per-cycle vector table for the
// basic transactions, hand-written sequences for full-queue, B backpressure
// and mid-burst reset, then randomized traffic against a queue-based model.
module tb_axi_b_resp_gen;

  logic        aclk = 1'b0;
  logic        rst_n;
  logic        awvalid_i;
  logic        awready_o;
  logic [7:0]  awid_i;
  logic [31:0] awaddr_i;
  logic [7:0]  awlen_i;
  logic        wvalid_i;
  logic        wlast_i;
  logic        wready_o;
  logic        bvalid_o;
  logic        bready_i;
  logic [7:0]  bid_o;
  logic [1:0]  bresp_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  localparam logic [31:0] WIN_END = 32'h0001_0000;
`ifdef AXI_B_RESP_LEN_CHECK_EN
  localparam logic [1:0] EARLY_RESP = 2'b10;
`else
  localparam logic [1:0] EARLY_RESP = 2'b00;
`endif

  always #5 aclk = ~aclk;

  axi_b_resp_gen #(
    .IdWidth   (8),
    .AddrWidth (32),
    .LenWidth  (8),
    .AwDepth   (4),
    .BaseAddr  (32'h0000_0000),
    .SizeBytes (32'h0001_0000)
  ) dut (
    .aclk      (aclk),
    .rst_n     (rst_n),
    .awvalid_i (awvalid_i),
    .awready_o (awready_o),
    .awid_i    (awid_i),
    .awaddr_i  (awaddr_i),
    .awlen_i   (awlen_i),
    .wvalid_i  (wvalid_i),
    .wlast_i   (wlast_i),
    .wready_o  (wready_o),
    .bvalid_o  (bvalid_o),
    .bready_i  (bready_i),
    .bid_o     (bid_o),
    .bresp_o   (bresp_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic awv, input logic [7:0] id, input logic [31:0] addr,
                       input logic [7:0] len, input logic wv, input logic wl, input logic br);
    awvalid_i = awv;
    awid_i    = id;
    awaddr_i  = addr;
    awlen_i   = len;
    wvalid_i  = wv;
    wlast_i   = wl;
    bready_i  = br;
  endtask

  typedef struct {
    logic        awv;
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic        wv;
    logic        wl;
    logic        br;
    logic        e_awr;
    logic        e_wr;
    logic        e_bv;
    logic [7:0]  e_bid;
    logic [1:0]  e_resp;
  } vec_t;

  function automatic vec_t v(input logic awv, input logic [7:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic wv, input logic wl,
                             input logic br, input logic e_awr, input logic e_wr,
                             input logic e_bv, input logic [7:0] e_bid, input logic [1:0] e_resp);
    vec_t r;
    r.awv = awv; r.id = id; r.addr = addr; r.len = len;
    r.wv = wv; r.wl = wl; r.br = br;
    r.e_awr = e_awr; r.e_wr = e_wr; r.e_bv = e_bv; r.e_bid = e_bid; r.e_resp = e_resp;
    return r;
  endfunction

  typedef struct {
    logic [7:0] id;
    int         len;
    bit         err;
  } m_entry_t;

  m_entry_t   mq[$];
  int         m_beat;
  logic       m_bv;
  logic [7:0] m_bid;
  logic [1:0] m_resp;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];

    //        awv id     addr          len wv wl br | awr wr bv bid    resp
    tbl.push_back(v(1, 8'h13, 32'h0000_0100, 3, 0, 0, 1, 1, 0, 0, 8'h00, 2'b00));
    tbl.push_back(v(0, 8'h00, 32'h0,         0, 1, 0, 1, 1, 1, 0, 8'h00, 2'b00));
    tbl.push_back(v(0, 8'h00, 32'h0,         0, 1, 0, 1, 1, 1, 0, 8'h00, 2'b00));
    tbl.push_back(v(0, 8'h00, 32'h0,         0, 1, 0, 1, 1, 1, 0, 8'h00, 2'b00));
    tbl.push_back(v(0, 8'h00, 32'h0,         0, 1, 1, 1, 1, 1, 0, 8'h00, 2'b00));
    tbl.push_back(v(0, 8'h00, 32'h0,         0, 0, 0, 1, 1, 0, 1, 8'h13, 2'b00));
    tbl.push_back(v(1, 8'h2A, 32'h0002_0000, 0, 0, 0, 1, 1, 0, 0, 8'h00, 2'b00));
    tbl.push_back(v(0, 8'h00, 32'h0,         0, 1, 1, 1, 1, 1, 0, 8'h00, 2'b00));
    tbl.push_back(v(0, 8'h00, 32'h0,         0, 0, 0, 1, 1, 0, 1, 8'h2A, 2'b10));
    tbl.push_back(v(1, 8'h3C, 32'h0000_FFFF, 0, 0, 0, 1, 1, 0, 0, 8'h00, 2'b00));
    tbl.push_back(v(0, 8'h00, 32'h0,         0, 1, 1, 1, 1, 1, 0, 8'h00, 2'b00));
    tbl.push_back(v(1, 8'h3D, 32'h0001_0000, 0, 0, 0, 1, 1, 0, 1, 8'h3C, 2'b00));
    tbl.push_back(v(0, 8'h00, 32'h0,         0, 1, 1, 1, 1, 1, 0, 8'h00, 2'b00));
    tbl.push_back(v(1, 8'h55, 32'h0000_0200, 3, 0, 0, 1, 1, 0, 1, 8'h3D, 2'b10));
    tbl.push_back(v(0, 8'h00, 32'h0,         0, 1, 0, 1, 1, 1, 0, 8'h00, 2'b00));
    tbl.push_back(v(0, 8'h00, 32'h0,         0, 1, 0, 1, 1, 1, 0, 8'h00, 2'b00));
    tbl.push_back(v(0, 8'h00, 32'h0,         0, 1, 1, 1, 1, 1, 0, 8'h00, 2'b00));
    tbl.push_back(v(0, 8'h00, 32'h0,         0, 0, 0, 1, 1, 0, 1, 8'h55, EARLY_RESP));
    tbl.push_back(v(0, 8'h00, 32'h0,         0, 0, 0, 1, 1, 0, 0, 8'h00, 2'b00));

    // Reset state
    rst_n = 1'b0;
    drive(0, 8'h0, 32'h0, 8'h0, 0, 0, 1);
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_awready", awready_o, 1'b0);
    chk("rst_wready",  wready_o,  1'b0);
    chk("rst_bvalid",  bvalid_o,  1'b0);
    chk("rst_bid",     bid_o,     8'h00);
    chk("rst_bresp",   bresp_o,   2'b00);
    @(negedge aclk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge aclk);
      drive(tbl[i].awv, tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].wv, tbl[i].wl, tbl[i].br);
      #1;
      chk($sformatf("vec%0d_awready", i), awready_o, tbl[i].e_awr);
      chk($sformatf("vec%0d_wready", i),  wready_o,  tbl[i].e_wr);
      chk($sformatf("vec%0d_bvalid", i),  bvalid_o,  tbl[i].e_bv);
      if (tbl[i].e_bv) begin
        chk($sformatf("vec%0d_bid", i),   bid_o,   tbl[i].e_bid);
        chk($sformatf("vec%0d_bresp", i), bresp_o, tbl[i].e_resp);
      end
    end

    // Fill the AW queue with W held off, then drain in order
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      drive(1, 8'h10 + 8'(k), 32'(k) * 32'h4, 8'h0, 0, 0, 1);
      #1;
      chk($sformatf("full_awready%0d", k), awready_o, 1'b1);
    end
    @(negedge aclk);
    drive(0, 8'h0, 32'h0, 8'h0, 0, 0, 1);
    #1;
    chk("full_awready_low", awready_o, 1'b0);
    @(negedge aclk);
    drive(0, 8'h0, 32'h0, 8'h0, 1, 1, 1);
    #1;
    chk("full_wready", wready_o, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      if (k == 3) wvalid_i = 1'b0;
      #1;
      chk($sformatf("drain_bvalid%0d", k), bvalid_o, 1'b1);
      chk($sformatf("drain_bid%0d", k),    bid_o,    8'h10 + 8'(k));
      if (k == 0) chk("drain_awready", awready_o, 1'b1);
    end
    @(negedge aclk);
    drive(0, 8'h0, 32'h0, 8'h0, 0, 0, 1);
    #1;
    chk("drain_bvalid_end", bvalid_o, 1'b0);

    // B backpressure with a second burst's wlast pending
    @(negedge aclk);
    drive(1, 8'hA1, 32'h0000_0010, 8'h0, 0, 0, 0);
    @(negedge aclk);
    drive(1, 8'hA2, 32'h0003_0000, 8'h0, 0, 0, 0);
    @(negedge aclk);
    drive(0, 8'h0, 32'h0, 8'h0, 1, 1, 0);
    #1;
    chk("bp_wready_first", wready_o, 1'b1);
    for (int j = 0; j < 5; j++) begin
      @(negedge aclk);
      #1;
      chk($sformatf("bp_bvalid%0d", j), bvalid_o, 1'b1);
      chk($sformatf("bp_bid%0d", j),    bid_o,    8'hA1);
      chk($sformatf("bp_bresp%0d", j),  bresp_o,  2'b00);
      chk($sformatf("bp_wready%0d", j), wready_o, 1'b0);
    end
    @(negedge aclk);
    bready_i = 1'b1;
    #1;
    chk("bp_release_wready", wready_o, 1'b1);
    chk("bp_release_bid",    bid_o,    8'hA1);
    @(negedge aclk);
    wvalid_i = 1'b0;
    wlast_i  = 1'b0;
    #1;
    chk("bp_b2b_bvalid", bvalid_o, 1'b1);
    chk("bp_b2b_bid",    bid_o,    8'hA2);
    chk("bp_b2b_bresp",  bresp_o,  2'b10);
    @(negedge aclk);
    #1;
    chk("bp_end_bvalid", bvalid_o, 1'b0);

    // Reset in the middle of a 4-beat burst
    @(negedge aclk);
    drive(1, 8'h66, 32'h0000_0300, 8'h3, 0, 0, 1);
    @(negedge aclk);
    drive(0, 8'h0, 32'h0, 8'h0, 1, 0, 1);
    @(negedge aclk);
    @(negedge aclk);
    rst_n = 1'b0;
    wvalid_i = 1'b0;
    #1;
    chk("mrst_bvalid",  bvalid_o,  1'b0);
    chk("mrst_awready", awready_o, 1'b0);
    chk("mrst_wready",  wready_o,  1'b0);
    @(negedge aclk);
    rst_n = 1'b1;
    #1;
    chk("mrst_rel_awready", awready_o, 1'b1);
    chk("mrst_rel_wready",  wready_o,  1'b0);
    chk("mrst_rel_bvalid",  bvalid_o,  1'b0);
    @(negedge aclk);
    drive(1, 8'h67, 32'h0000_0040, 8'h1, 0, 0, 1);
    @(negedge aclk);
    drive(0, 8'h0, 32'h0, 8'h0, 1, 0, 1);
    #1;
    chk("mrst_new_wready", wready_o, 1'b1);
    @(negedge aclk);
    wlast_i = 1'b1;
    @(negedge aclk);
    drive(0, 8'h0, 32'h0, 8'h0, 0, 0, 1);
    #1;
    chk("mrst_new_bvalid", bvalid_o, 1'b1);
    chk("mrst_new_bid",    bid_o,    8'h67);
    chk("mrst_new_bresp",  bresp_o,  2'b00);
    @(negedge aclk);
    #1;
    chk("mrst_new_bvalid_clr", bvalid_o, 1'b0);

    // Randomized traffic against the queue model
    @(negedge aclk);
    rst_n = 1'b0;
    drive(0, 8'h0, 32'h0, 8'h0, 0, 0, 1);
    @(negedge aclk);
    rst_n = 1'b1;
    mq.delete();
    m_beat = 0;
    m_bv   = 1'b0;
    m_bid  = 8'h00;
    m_resp = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      logic        e_awr;
      logic        e_wr;
      logic        at_last;
      logic        ends;
      logic        lerr;
      logic        end_hs;
      logic [31:0] addr;
      m_entry_t    ne;

      @(negedge aclk);
      chk("rnd_bvalid", bvalid_o, m_bv);
      if (m_bv) begin
        chk("rnd_bid",   bid_o,   m_bid);
        chk("rnd_bresp", bresp_o, m_resp);
      end

      case ($urandom_range(0, 5))
        0:       addr = 32'h0000_0000;
        1:       addr = 32'h0000_FFFF;
        2:       addr = 32'h0001_0000;
        3:       addr = 32'hFFFF_FFF0;
        default: addr = $urandom;
      endcase
      awvalid_i = ($urandom_range(0, 1) == 1);
      awid_i    = 8'($urandom);
      awaddr_i  = addr;
      awlen_i   = 8'($urandom_range(0, 3));
      wvalid_i  = ($urandom_range(0, 2) != 0);
      bready_i  = ($urandom_range(0, 3) != 0);
      if (mq.size() > 0 && $urandom_range(0, 9) < 8)
        wlast_i = (m_beat == mq[0].len);
      else
        wlast_i = ($urandom_range(0, 1) == 1);
      #1;

      at_last = (mq.size() > 0) && (m_beat == mq[0].len);
`ifdef AXI_B_RESP_LEN_CHECK_EN
      ends = wlast_i || at_last;
      lerr = (wlast_i != at_last);
`else
      ends = wlast_i;
      lerr = 1'b0;
`endif
      e_awr = (mq.size() < 4);
      e_wr  = (mq.size() > 0) && !(ends && m_bv && !bready_i);
      chk("rnd_awready", awready_o, e_awr);
      chk("rnd_wready",  wready_o,  e_wr);

      end_hs = wvalid_i && e_wr && ends;
      if (end_hs) begin
        m_bv   = 1'b1;
        m_bid  = mq[0].id;
        m_resp = (mq[0].err || lerr) ? 2'b10 : 2'b00;
        void'(mq.pop_front());
        m_beat = 0;
      end else begin
        if (wvalid_i && e_wr) m_beat++;
        if (bready_i) m_bv = 1'b0;
      end
      if (awvalid_i && e_awr) begin
        ne.id  = awid_i;
        ne.len = int'(awlen_i);
        ne.err = !(awaddr_i < WIN_END);
        mq.push_back(ne);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
